morse_keyer: RTL and testbench

- Transmit-side counterpart of the pushbutton SHORT/LONG decoder. It turns a character code into timed dot/dash on/off keying on KEY, which drives an LED or buzzer.
- Accepts one character per valid/ready handshake and looks up its ITU Morse pattern.
- Emits marks and spaces in integer multiples of a unit time, then pulses DONE.
- Sits between the character source (FSM or UART front end) and the output driver pin.

---
 rtl/morse_keyer.sv | 154 +++++++++++++++
 tb/tb_morse_keyer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_keyer.sv
// Morse transmit keyer: accepts one character code per valid/ready handshake
// and keys ITU dot/dash marks and spaces in multiples of UNIT_CYCLES, then pulses DONE.
module morse_keyer #(
   parameter int UNIT_CYCLES = 8388608,
   parameter int COUNT_W     = 28
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [5:0] CHAR,
   input  logic       VALID,
   output logic       READY,
   output logic       KEY,
   output logic       DONE,
   output logic       ERR
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MARK  = 3'd1,
      SPACE = 3'd2,
      CGAP  = 3'd3,
      WGAP  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [COUNT_W-1:0] cyc_cnt;
   logic [2:0] unit_cnt, elem_idx, len_q, seg_units;
   logic [4:0] pat_q;
   logic [2:0] lut_len;
   logic [4:0] lut_pat;
   logic [3:0] dig;
   logic accept, is_sym, is_word, tick, seg_end, last_elem;
   logic key_d, ready_d, done_d, err_d;

   // Digits 26..35: low nibble is 10..15,0..3, so +6 (mod 16) gives 0..9.
   assign dig = CHAR[3:0] + 4'd6;

   always_comb begin
      lut_len = 3'd0;
      lut_pat = 5'b00000;
      case (CHAR)
         6'd0:  begin lut_len = 3'd2; lut_pat = 5'b01000; end
         6'd1:  begin lut_len = 3'd4; lut_pat = 5'b10000; end
         6'd2:  begin lut_len = 3'd4; lut_pat = 5'b10100; end
         6'd3:  begin lut_len = 3'd3; lut_pat = 5'b10000; end
         6'd4:  begin lut_len = 3'd1; lut_pat = 5'b00000; end
         6'd5:  begin lut_len = 3'd4; lut_pat = 5'b00100; end
         6'd6:  begin lut_len = 3'd3; lut_pat = 5'b11000; end
         6'd7:  begin lut_len = 3'd4; lut_pat = 5'b00000; end
         6'd8:  begin lut_len = 3'd2; lut_pat = 5'b00000; end
         6'd9:  begin lut_len = 3'd4; lut_pat = 5'b01110; end
         6'd10: begin lut_len = 3'd3; lut_pat = 5'b10100; end
         6'd11: begin lut_len = 3'd4; lut_pat = 5'b01000; end
         6'd12: begin lut_len = 3'd2; lut_pat = 5'b11000; end
         6'd13: begin lut_len = 3'd2; lut_pat = 5'b10000; end
         6'd14: begin lut_len = 3'd3; lut_pat = 5'b11100; end
         6'd15: begin lut_len = 3'd4; lut_pat = 5'b01100; end
         6'd16: begin lut_len = 3'd4; lut_pat = 5'b11010; end
         6'd17: begin lut_len = 3'd3; lut_pat = 5'b01000; end
         6'd18: begin lut_len = 3'd3; lut_pat = 5'b00000; end
         6'd19: begin lut_len = 3'd1; lut_pat = 5'b10000; end
         6'd20: begin lut_len = 3'd3; lut_pat = 5'b00100; end
         6'd21: begin lut_len = 3'd4; lut_pat = 5'b00010; end
         6'd22: begin lut_len = 3'd3; lut_pat = 5'b01100; end
         6'd23: begin lut_len = 3'd4; lut_pat = 5'b10010; end
         6'd24: begin lut_len = 3'd4; lut_pat = 5'b10110; end
         6'd25: begin lut_len = 3'd4; lut_pat = 5'b11000; end
         default: begin
            if (CHAR >= 6'd26 && CHAR <= 6'd35) begin
               lut_len = 3'd5;
               // 0-5: leading dots then dashes; 6-9: leading dashes then dots
               if (dig <= 4'd5) lut_pat = 5'b11111 >> dig;
               else             lut_pat = ~(5'b11111 >> (dig - 4'd5));
            end
         end
      endcase
   end

   assign is_sym    = (CHAR <= 6'd35);
   assign is_word   = (CHAR == 6'd36);
   assign accept    = VALID && READY;
   assign tick      = (state != IDLE) && (cyc_cnt == COUNT_W'(UNIT_CYCLES - 1));
   assign last_elem = (elem_idx == len_q - 3'd1);

   always_comb begin
      case (state)
         MARK:    seg_units = pat_q[4] ? 3'd3 : 3'd1;
         CGAP:    seg_units = 3'd3;
         WGAP:    seg_units = 3'd7;
         default: seg_units = 3'd1;
      endcase
   end

   assign seg_end = tick && (unit_cnt == seg_units - 3'd1);

   // State and datapath registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         cyc_cnt  <= '0;
         unit_cnt <= 3'd0;
         elem_idx <= 3'd0;
         len_q    <= 3'd0;
         pat_q    <= 5'b00000;
         READY    <= 1'b1;
         KEY      <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
      end else begin
         state <= state_nxt;
         READY <= ready_d;
         KEY   <= key_d;
         DONE  <= done_d;
         ERR   <= err_d;
         if (state == IDLE || tick) cyc_cnt <= '0;
         else                      cyc_cnt <= cyc_cnt + 1'b1;
         if (state == IDLE || seg_end) unit_cnt <= 3'd0;
         else if (tick)                unit_cnt <= unit_cnt + 3'd1;
         if (state == IDLE) begin
            elem_idx <= 3'd0;
            if (accept) begin
               len_q <= lut_len;
               pat_q <= lut_pat;
            end
         end else if (state == MARK && seg_end && !last_elem) begin
            elem_idx <= elem_idx + 3'd1;
            pat_q    <= {pat_q[3:0], 1'b0};
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && is_sym)       state_nxt = MARK;
            else if (accept && is_word) state_nxt = WGAP;
         end
         MARK:  if (seg_end) state_nxt = last_elem ? CGAP : SPACE;
         SPACE: if (seg_end) state_nxt = MARK;
         CGAP, WGAP: if (seg_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      key_d   = (state_nxt == MARK);
      ready_d = (state_nxt == IDLE);
      done_d  = seg_end && (state == CGAP || state == WGAP);
      err_d   = (state == IDLE) && accept && !is_sym && !is_word;
   end

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: two instances (U=4, U=2) share stimulus; expected keying
// is built from ITU dot/dash strings and unit timing rules.
module tb_morse_keyer;

   logic clk = 1'b0;
   logic rst;
   logic [5:0] char_in;
   logic valid;
   logic ready4, key4, done4, err4;
   logic ready2, key2, done2, err2;
   logic ready, key, done, err;
   bit sel;

   int checks = 0;
   int errors = 0;

   bit exp_q[$];
   int exp_rises;

   string tab [36] = '{".-","-...","-.-.","-..",".","..-.","--.","....","..",".---",
                       "-.-",".-..","--","-.","---",".--.","--.-",".-.","...","-",
                       "..-","...-",".--","-..-","-.--","--..",
                       "-----",".----","..---","...--","....-",
                       ".....","-....","--...","---..","----."};

   always #5 clk = ~clk;

   morse_keyer #(.UNIT_CYCLES(4), .COUNT_W(28)) dut4 (
      .CLK(clk), .RESET(rst), .CHAR(char_in), .VALID(valid),
      .READY(ready4), .KEY(key4), .DONE(done4), .ERR(err4));

   morse_keyer #(.UNIT_CYCLES(2), .COUNT_W(28)) dut2 (
      .CLK(clk), .RESET(rst), .CHAR(char_in), .VALID(valid),
      .READY(ready2), .KEY(key2), .DONE(done2), .ERR(err2));

   assign ready = sel ? ready2 : ready4;
   assign key   = sel ? key2   : key4;
   assign done  = sel ? done2  : done4;
   assign err   = sel ? err2   : err4;

   // Expected KEY per cycle after accept, from the dot/dash string.
   task automatic build(input int c, input int u);
      string s;
      exp_q.delete();
      exp_rises = 0;
      if (c == 36) begin
         for (int k = 0; k < 7*u; k++) exp_q.push_back(1'b0);
      end else begin
         s = tab[c];
         for (int i = 0; i < s.len(); i++) begin
            exp_rises++;
            for (int k = 0; k < ((s[i] == "-") ? 3*u : u); k++) exp_q.push_back(1'b1);
            for (int k = 0; k < ((i == s.len()-1) ? 3*u : u); k++) exp_q.push_back(1'b0);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; valid = 1'b0; char_in = 6'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Caller has set CHAR/VALID at a negedge with READY=1; returns at the DONE-cycle negedge.
   task automatic check_char(input int code, input bit junk);
      int u, rises;
      bit prev;
      u = sel ? 2 : 4;
      build(code, u);
      @(posedge clk);
      prev = 1'b0; rises = 0;
      for (int n = 0; n < exp_q.size(); n++) begin
         @(negedge clk);
         if (junk) begin valid = 1'($urandom); char_in = 6'($urandom); end
         else valid = 1'b0;
         checks++;
         if (key !== exp_q[n] || ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL seq char=%0d cycle=%0d key=%b ready=%b done=%b err=%b required key=%b ready=0 done=0 err=0",
                     code, n+1, key, ready, done, err, exp_q[n]);
         end
         if (key === 1'b1 && !prev) rises++;
         prev = (key === 1'b1);
      end
      @(negedge clk);
      valid = 1'b0;
      checks++;
      if (done !== 1'b1 || ready !== 1'b1 || key !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL done_cycle char=%0d cycle=%0d done=%b ready=%b key=%b err=%b required 1 1 0 0",
                  code, exp_q.size()+1, done, ready, key, err);
      end
      checks++;
      if (rises !== exp_rises) begin
         errors++;
         $display("FAIL rises char=%0d got=%0d required=%0d", code, rises, exp_rises);
      end
   endtask

   task automatic check_done_low(input string name);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || key !== 1'b0) begin
         errors++;
         $display("FAIL %s done=%b ready=%b key=%b required 0 1 0", name, done, ready, key);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; valid = 1'b0; char_in = 6'd0;
      @(negedge clk);
      checks++;
      if ({ready4, key4, done4, err4, ready2, key2, done2, err2} !== 8'b1000_1000) begin
         errors++;
         $display("FAIL reset got=%b%b%b%b_%b%b%b%b required=1000_1000",
                  ready4, key4, done4, err4, ready2, key2, done2, err2);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_e();
      sel = 1'b0; do_reset();
      char_in = 6'd4; valid = 1'b1;
      check_char(4, 1'b0);
      check_done_low("e_done_low");
   endtask

   task automatic test_a();
      sel = 1'b0; do_reset();
      char_in = 6'd0; valid = 1'b1;
      check_char(0, 1'b0);
      check_done_low("a_done_low");
   endtask

   task automatic test_back_to_back();
      sel = 1'b1; do_reset();
      char_in = 6'd26; valid = 1'b1;
      check_char(26, 1'b0);
      char_in = 6'd36; valid = 1'b1;
      check_char(36, 1'b0);
      check_done_low("b2b_done_low");
   endtask

   task automatic test_err();
      int code;
      sel = 1'($urandom); do_reset();
      code = $urandom_range(37, 63);
      char_in = 6'(code); valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      checks++;
      if (err !== 1'b1 || ready !== 1'b1 || key !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse code=%0d err=%b ready=%b key=%b done=%b required 1 1 0 0",
                  code, err, ready, key, done);
      end
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || ready !== 1'b1 || key !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL err_after code=%0d cycle=%0d err=%b ready=%b key=%b done=%b required 0 1 0 0",
                     code, n, err, ready, key, done);
         end
      end
   endtask

   task automatic test_ignore();
      sel = 1'b0; do_reset();
      char_in = 6'd19; valid = 1'b1;
      check_char(19, 1'b1);
      check_done_low("ignore_done_low");
   endtask

   task automatic test_mid_reset();
      sel = 1'b0; do_reset();
      char_in = 6'd19; valid = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         valid = 1'b0;
      end
      checks++;
      if (key !== 1'b1) begin
         errors++;
         $display("FAIL mid_dash_key key=%b required 1", key);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (key !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset key=%b ready=%b done=%b required 0 1 0", key, ready, done);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 30; n++) check_done_low("after_reset_idle");
      char_in = 6'd4; valid = 1'b1;
      check_char(4, 1'b0);
   endtask

   task automatic test_random();
      int code;
      for (int it = 0; it < 16; it++) begin
         if (it % 4 == 0) begin
            sel = 1'($urandom);
            do_reset();
         end else if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
         end
         code = $urandom_range(0, 36);
         char_in = 6'(code); valid = 1'b1;
         check_char(code, 1'($urandom));
      end
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; char_in = 6'd0; sel = 1'b0;
      test_reset();
      test_e();
      test_a();
      test_back_to_back();
      test_err();
      test_ignore();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
